// File: rtl/stream_upsizer.sv
//==============================================================================
// Module   : stream_upsizer
// Brief    : Packs SCALE narrow valid/ready words into one wide word, LSB first.
//            Optional packet flush via `define STREAM_UPSIZER_FLUSH_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module stream_upsizer #(
    parameter int DW_IN = 16,
    parameter int SCALE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW_IN-1:0]       s_data_i,
    input  logic                   s_valid_i,
`ifdef STREAM_UPSIZER_FLUSH_EN
    input  logic                   s_last_i,
    output logic                   m_last_o,
`endif
    output logic                   s_ready_o,
    output logic [DW_IN*SCALE-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);

    localparam int DW_OUT = DW_IN * SCALE;
    localparam int CW     = $clog2(SCALE);
    localparam logic [CW-1:0] c_last_slice = CW'(SCALE - 1);

    logic [CW-1:0]     r_cnt;
    logic [DW_OUT-1:0] r_data;
    logic              r_valid;
    logic [DW_OUT-1:0] w_final_data;
    logic              w_is_final;
    logic              w_s_fire;

`ifdef STREAM_UPSIZER_FLUSH_EN
    logic r_last;
    assign w_is_final = (r_cnt == c_last_slice) || s_last_i;
    assign m_last_o   = r_last;
`else
    assign w_is_final = (r_cnt == c_last_slice);
`endif

    // A final slice may only enter when the output register is free or draining.
    assign s_ready_o = !w_is_final || !r_valid || m_ready_i;
    assign w_s_fire  = s_valid_i && s_ready_o;

    // Wide word built from the slices below cnt, the incoming word at cnt, zeros above.
    for (genvar i = 0; i < SCALE; i++) begin : g_slice
        if (i < SCALE - 1) begin : g_acc
            logic [DW_IN-1:0] r_slice;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slice <= '0;
                end else if (w_s_fire && !w_is_final && (r_cnt == CW'(i))) begin
                    r_slice <= s_data_i;
                end
            end

            assign w_final_data[i*DW_IN +: DW_IN] =
                (r_cnt == CW'(i)) ? s_data_i :
                (CW'(i) < r_cnt)  ? r_slice  : '0;
        end else begin : g_top
            assign w_final_data[i*DW_IN +: DW_IN] = (r_cnt == CW'(i)) ? s_data_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_s_fire && w_is_final) begin
                r_cnt   <= '0;
                r_data  <= w_final_data;
                r_valid <= 1'b1;
            end else begin
                if (m_ready_i) begin
                    r_valid <= 1'b0;
                end
                if (w_s_fire) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

`ifdef STREAM_UPSIZER_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_s_fire && w_is_final) begin
            r_last <= s_last_i;
        end
    end
`endif

    assign m_data_o  = r_data;
    assign m_valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_upsizer.sv
//==============================================================================
// Module   : tb_stream_upsizer
// Brief    : Self-checking bench for stream_upsizer against a queue-based model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_stream_upsizer;

    localparam int DW_IN  = 16;
    localparam int SCALE  = 3;
    localparam int DW_OUT = DW_IN * SCALE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW_IN-1:0]  s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DW_OUT-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;

    stream_upsizer #(.DW_IN(DW_IN), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    // Reference model: narrow words gathered so far, and wide words awaiting output.
    logic [DW_IN-1:0]  narrow_q[$];
    logic [DW_OUT-1:0] out_q[$];

    task automatic chk(input string tag, input logic [DW_OUT-1:0] obs, input logic [DW_OUT-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW_OUT-1:0] pack_words();
        logic [DW_OUT-1:0] w = '0;
        for (int k = 0; k < SCALE; k++) begin
            w = w | (DW_OUT'(narrow_q[k]) << (k * DW_IN));
        end
        return w;
    endfunction

    task automatic do_reset();
        s_valid_i = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        narrow_q.delete();
        out_q.delete();
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [DW_IN-1:0] d, input logic mr, output logic acc);
        logic exp_rdy;
        logic vld_b;
        logic rdy_b;
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = mr;
        #1;
        exp_rdy = (narrow_q.size() != SCALE - 1) || (out_q.size() == 0) || mr;
        chk("s_ready", DW_OUT'(s_ready_o), DW_OUT'(exp_rdy));
        chk("m_valid", DW_OUT'(m_valid_o), DW_OUT'(out_q.size() != 0));
        if (out_q.size() != 0) begin
            chk("m_data", m_data_o, out_q[0]);
        end
        vld_b = m_valid_o;
        rdy_b = s_ready_o;
        @(posedge clk);
        #1;
        if (vld_b && mr && out_q.size() != 0) begin
            void'(out_q.pop_front());
            n_out++;
        end
        acc = v && rdy_b;
        if (acc) begin
            narrow_q.push_back(d);
            if (narrow_q.size() == SCALE) begin
                out_q.push_back(pack_words());
                narrow_q.delete();
            end
        end
    endtask

    initial begin
        logic a;
        logic [DW_OUT-1:0] held;
        int rdy_drops;
        int out_base;

        // Reset state
        @(posedge clk);
        #1;
        do_reset();
        #1;
        chk("reset_valid", DW_OUT'(m_valid_o), '0);
        chk("reset_data", m_data_o, '0);
        chk("reset_ready", DW_OUT'(s_ready_o), DW_OUT'(1));

        // Single word
        cycle(1'b1, 16'h1111, 1'b1, a);
        cycle(1'b1, 16'h2222, 1'b1, a);
        chk("single_pre_valid", DW_OUT'(m_valid_o), '0);
        cycle(1'b1, 16'h3333, 1'b1, a);
        chk("single_valid", DW_OUT'(m_valid_o), DW_OUT'(1));
        chk("single_data", m_data_o, 48'h3333_2222_1111);
        cycle(1'b0, 16'h0, 1'b1, a);
        chk("single_one_cycle", DW_OUT'(m_valid_o), '0);

        // Back-to-back with ready held high
        rdy_drops = 0;
        out_base  = n_out;
        for (int i = 0; i < 3 * 5461; i++) begin
            cycle(1'b1, 16'($urandom), 1'b1, a);
            if (!a) rdy_drops++;
        end
        cycle(1'b0, 16'h0, 1'b1, a);
        chk("b2b_ready_drops", DW_OUT'(rdy_drops), '0);
        chk("b2b_word_count", DW_OUT'(n_out - out_base), DW_OUT'(5461));

        // Back-pressure
        cycle(1'b1, 16'hA001, 1'b1, a);
        cycle(1'b1, 16'hA002, 1'b1, a);
        cycle(1'b1, 16'hA003, 1'b1, a);
        held = m_data_o;
        chk("bp_first_word", held, 48'hA003_A002_A001);
        cycle(1'b1, 16'hB001, 1'b0, a);
        chk("bp_accept1", DW_OUT'(a), DW_OUT'(1));
        cycle(1'b1, 16'hB002, 1'b0, a);
        chk("bp_accept2", DW_OUT'(a), DW_OUT'(1));
        cycle(1'b1, 16'hB003, 1'b0, a);
        chk("bp_blocked", DW_OUT'(a), '0);
        chk("bp_held", m_data_o, held);
        cycle(1'b1, 16'hB003, 1'b1, a);
        chk("bp_release_accept", DW_OUT'(a), DW_OUT'(1));
        chk("bp_second_word", m_data_o, 48'hB003_B002_B001);
        cycle(1'b0, 16'h0, 1'b1, a);

        // Reset mid-word
        cycle(1'b1, 16'hAAAA, 1'b1, a);
        cycle(1'b1, 16'hBBBB, 1'b1, a);
        do_reset();
        cycle(1'b1, 16'h1111, 1'b1, a);
        cycle(1'b1, 16'h2222, 1'b1, a);
        chk("rst_mid_no_early", DW_OUT'(m_valid_o), '0);
        cycle(1'b1, 16'h3333, 1'b1, a);
        chk("rst_mid_data", m_data_o, 48'h3333_2222_1111);
        cycle(1'b0, 16'h0, 1'b1, a);

        // Reset with a pending wide word
        cycle(1'b1, 16'h0101, 1'b0, a);
        cycle(1'b1, 16'h0202, 1'b0, a);
        cycle(1'b1, 16'h0303, 1'b0, a);
        do_reset();
        #1;
        chk("rst_pending_valid", DW_OUT'(m_valid_o), '0);
        chk("rst_pending_data", m_data_o, '0);

        // Random valid / ready rates
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), a);
        end

        // Drain whatever is left
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 1'b1, a);
        end
        chk("drain_empty", DW_OUT'(out_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
